// File: rtl/odd_number_pkg.sv
// ---------------------------------------------------------------------------
// odd_number_pkg: state encodings and default sizes shared by the requester
// and the odd-number analyzer.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package odd_number_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_TIMEOUT = 15;
    localparam int DEF_CNT_W   = 8;

    typedef enum logic [2:0] {
        REQ_IDLE    = 3'd0,
        REQ_SETUP   = 3'd1,
        REQ_RUN     = 3'd2,
        REQ_DONE    = 3'd3,
        REQ_RECOVER = 3'd4
    } req_state_t;

    // Analyzer-side encodings, kept here so the analyzer can import them.
    typedef enum logic [1:0] {
        AN_IDLE   = 2'd0,
        AN_SAMPLE = 2'd1,
        AN_WAIT   = 2'd2,
        AN_REPORT = 2'd3
    } an_state_t;

endpackage

`default_nettype wire

// File: rtl/odd_number_requester_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter: up-counter that sticks at its all-ones value.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/odd_number_requester.sv
// ---------------------------------------------------------------------------
// odd_number_requester: feeds one number at a time to the odd-number analyzer,
// waits for its verdict with a timeout and keeps saturating odd/even tallies.
// Optional macro: ODD_NUMBER_REQUESTER_SELFCHECK_EN (verdict vs. in_data[0]).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module odd_number_requester
    import odd_number_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             an_number,
    output logic             an_enable,
    input  logic             an_ready,
    input  logic             an_is_odd,
    output logic             res_valid,
    output logic             res_is_odd,
    output logic             res_timeout,
    output logic             res_mismatch,
    output logic [CNT_W-1:0] odd_count,
    output logic [CNT_W-1:0] even_count
);

    req_state_t state;
    req_state_t state_next;
    logic       captured_lsb;
    logic [7:0] wait_cnt;
    logic       run_expire;
    logic       run_finish;
    logic       odd_inc;
    logic       even_inc;

    // Parity is all the analyzer sees; the upper bits are accepted but unused.
    logic       unused_data_bits;
    assign unused_data_bits = ^in_data[WIDTH-1:1];

    assign run_expire = (wait_cnt == 8'(TIMEOUT));
    assign run_finish = (state == REQ_RUN) && (an_ready || run_expire);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= REQ_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        an_enable  = 1'b0;
        an_number  = 1'b0;
        res_valid  = 1'b0;
        case (state)
            REQ_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = REQ_SETUP;
            end
            REQ_SETUP: begin
                an_number  = captured_lsb;
                state_next = REQ_RUN;
            end
            REQ_RUN: begin
                an_number = captured_lsb;
                an_enable = 1'b1;
                if (an_ready || run_expire) state_next = REQ_DONE;
            end
            REQ_DONE: begin
                an_number  = captured_lsb;
                res_valid  = 1'b1;
                state_next = REQ_RECOVER;
            end
            REQ_RECOVER: begin
                an_number  = captured_lsb;
                state_next = REQ_IDLE;
            end
            default: state_next = REQ_IDLE;
        endcase
    end

    // A ready seen on the final RUN cycle still counts as a real verdict.
    always_ff @(posedge clock) begin
        if (reset) begin
            captured_lsb <= 1'b0;
            wait_cnt     <= '0;
            res_is_odd   <= 1'b0;
            res_timeout  <= 1'b0;
        end else begin
            if ((state == REQ_IDLE) && in_valid) captured_lsb <= in_data[0];
            if (state == REQ_RUN) wait_cnt <= wait_cnt + 8'd1;
            else                  wait_cnt <= '0;
            if (run_finish) begin
                res_is_odd  <= an_ready & an_is_odd;
                res_timeout <= ~an_ready;
            end
        end
    end

`ifdef ODD_NUMBER_REQUESTER_SELFCHECK_EN
    logic mismatch_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            mismatch_q <= 1'b0;
        end else if (run_finish) begin
            mismatch_q <= an_ready & (an_is_odd ^ captured_lsb);
        end
    end

    assign res_mismatch = mismatch_q;
`else
    assign res_mismatch = 1'b0;
`endif

    assign odd_inc  = (state == REQ_DONE) && !res_timeout &&  res_is_odd;
    assign even_inc = (state == REQ_DONE) && !res_timeout && !res_is_odd;

    sat_counter #(.CNT_W(CNT_W)) u_odd_tally (
        .clock (clock),
        .reset (reset),
        .inc   (odd_inc),
        .count (odd_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_even_tally (
        .clock (clock),
        .reset (reset),
        .inc   (even_inc),
        .count (even_count)
    );

endmodule

`default_nettype wire

// File: tb/tb_odd_number_requester.sv
// ---------------------------------------------------------------------------
// tb_odd_number_requester: directed and randomized transactions against a
// behavioural analyzer and a transaction-level expectation model.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_odd_number_requester;

    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 15;
    localparam int CNT_W   = 8;
    localparam int CNT_WS  = 2;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             an_ready = 1'b0;
    logic             an_is_odd = 1'b0;

    logic              in_ready, an_number, an_enable;
    logic              res_valid, res_is_odd, res_timeout, res_mismatch;
    logic [CNT_W-1:0]  odd_count, even_count;
    logic              s_in_ready, s_an_number, s_an_enable;
    logic              s_res_valid, s_res_is_odd, s_res_timeout, s_res_mismatch;
    logic [CNT_WS-1:0] s_odd_count, s_even_count;

    odd_number_requester #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .an_number(an_number), .an_enable(an_enable),
        .an_ready(an_ready), .an_is_odd(an_is_odd), .res_valid(res_valid),
        .res_is_odd(res_is_odd), .res_timeout(res_timeout),
        .res_mismatch(res_mismatch), .odd_count(odd_count), .even_count(even_count)
    );

    // Narrow-tally copy on the same stimulus, used for saturation checks.
    odd_number_requester #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_WS)) dut_s (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(s_in_ready), .an_number(s_an_number), .an_enable(s_an_enable),
        .an_ready(an_ready), .an_is_odd(an_is_odd), .res_valid(s_res_valid),
        .res_is_odd(s_res_is_odd), .res_timeout(s_res_timeout),
        .res_mismatch(s_res_mismatch), .odd_count(s_odd_count), .even_count(s_even_count)
    );

    always #5 clock = ~clock;

    // Behavioural analyzer: ready (and verdict) appear resp_delay cycles after
    // enable is first sampled; resp_delay 0 means it never answers.
    int resp_delay = 2;
    bit lie        = 1'b0;
    bit noise      = 1'b0;
    int en_cnt     = 0;

    always @(posedge clock) begin
        if (an_enable) begin
            en_cnt <= en_cnt + 1;
            if (resp_delay != 0 && en_cnt + 1 >= resp_delay) begin
                an_ready  <= 1'b1;
                an_is_odd <= an_number ^ lie;
            end else begin
                an_ready  <= 1'b0;
                an_is_odd <= 1'b0;
            end
        end else begin
            en_cnt <= 0;
            if (noise && in_ready) begin
                an_ready  <= 1'($urandom);
                an_is_odd <= 1'($urandom);
            end else begin
                an_ready  <= 1'b0;
                an_is_odd <= 1'b0;
            end
        end
    end

    int vectors = 0;
    int errors  = 0;
    int m_odd = 0, m_even = 0, m_odd_s = 0, m_even_s = 0;
    bit m_res_odd = 0, m_res_to = 0, m_res_mm = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_inc(input int v, input int maxv);
        return (v < maxv) ? v + 1 : v;
    endfunction

    task automatic check_tallies();
        check("odd_count", 32'(odd_count), m_odd);
        check("even_count", 32'(even_count), m_even);
        check("odd_count_sat", 32'(s_odd_count), m_odd_s);
        check("even_count_sat", 32'(s_even_count), m_even_s);
    endtask

    // Called at a negedge with the requester idle; returns at the negedge of
    // the IDLE cycle that follows RECOVER.
    task automatic run_txn(input logic [7:0] data, input int d, input bit lie_i,
                           input bit hold, input logic [7:0] nxt);
        int  exp_n;
        bit  to;
        bit  exp_mm;
        resp_delay = d;
        lie        = lie_i;
        to         = (d == 0) || (d > TIMEOUT);
        exp_n      = to ? TIMEOUT + 3 : d + 3;
`ifdef ODD_NUMBER_REQUESTER_SELFCHECK_EN
        exp_mm     = !to && lie_i;
`else
        exp_mm     = 1'b0;
`endif
        check("in_ready_idle", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = data;
        @(posedge clock);
        @(negedge clock);
        if (hold) in_data = nxt;
        for (int n = 1; n < exp_n; n++) begin
            check("in_ready_busy", 32'(in_ready), 0);
            check("an_enable", 32'(an_enable), (n >= 2) ? 1 : 0);
            check("an_number", 32'(an_number), 32'(data[0]));
            check("res_valid_early", 32'(res_valid), 0);
            if (!hold) begin
                in_valid = 1'($urandom);
                in_data  = 8'($urandom);
            end
            @(negedge clock);
        end
        m_res_odd = to ? 1'b0 : (data[0] ^ lie_i);
        m_res_to  = to;
        m_res_mm  = exp_mm;
        check("res_valid", 32'(res_valid), 1);
        check("res_is_odd", 32'(res_is_odd), 32'(m_res_odd));
        check("res_timeout", 32'(res_timeout), 32'(m_res_to));
        check("res_mismatch", 32'(res_mismatch), 32'(m_res_mm));
        check("an_enable_done", 32'(an_enable), 0);
        if (!to) begin
            if (m_res_odd) begin
                m_odd   = sat_inc(m_odd, (1 << CNT_W) - 1);
                m_odd_s = sat_inc(m_odd_s, (1 << CNT_WS) - 1);
            end else begin
                m_even   = sat_inc(m_even, (1 << CNT_W) - 1);
                m_even_s = sat_inc(m_even_s, (1 << CNT_WS) - 1);
            end
        end
        @(negedge clock);
        check("res_valid_recover", 32'(res_valid), 0);
        check("an_enable_recover", 32'(an_enable), 0);
        check("in_ready_recover", 32'(in_ready), 0);
        check("an_number_recover", 32'(an_number), 32'(data[0]));
        check_tallies();
        if (!hold) in_valid = 1'b0;
        @(negedge clock);
        check("in_ready_back", 32'(in_ready), 1);
        check("an_number_idle", 32'(an_number), 0);
        check("res_is_odd_held", 32'(res_is_odd), 32'(m_res_odd));
        check("res_timeout_held", 32'(res_timeout), 32'(m_res_to));
    endtask

    logic [7:0] cur, pend;
    int         rd;
    bit         hold_r;

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_an_number", 32'(an_number), 0);
        check("rst_an_enable", 32'(an_enable), 0);
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_res_is_odd", 32'(res_is_odd), 0);
        check("rst_res_timeout", 32'(res_timeout), 0);
        check("rst_res_mismatch", 32'(res_mismatch), 0);
        check_tallies();
        reset = 1'b0;
        @(negedge clock);

        run_txn(8'h07, 2, 1'b0, 1'b0, 8'h00);
        run_txn(8'h10, 2, 1'b0, 1'b1, 8'h03);
        run_txn(8'h03, 2, 1'b0, 1'b0, 8'h00);
        run_txn(8'h55, 0, 1'b0, 1'b0, 8'h00);
        run_txn(8'h02, 2, 1'b1, 1'b0, 8'h00);
        run_txn(8'h20, TIMEOUT, 1'b0, 1'b0, 8'h00);
        run_txn(8'h21, TIMEOUT + 1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) run_txn(8'((i << 1) | 1), 1, 1'b0, 1'b0, 8'h00);
        check("odd_sat_stuck", 32'(s_odd_count), 3);

        noise = 1'b1;
        pend  = 8'($urandom);
        for (int t = 0; t < 24; t++) begin
            cur    = pend;
            pend   = 8'($urandom);
            rd     = $urandom_range(0, 9);
            hold_r = (t != 23) && ($urandom_range(0, 1) == 1);
            run_txn(cur,
                    (rd < 7) ? $urandom_range(1, 5) :
                    (rd == 7) ? 0 : $urandom_range(TIMEOUT - 1, TIMEOUT + 2),
                    ($urandom_range(0, 3) == 0), hold_r, pend);
        end
        noise = 1'b0;

        resp_delay = 0;
        in_valid   = 1'b1;
        in_data    = 8'h09;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        repeat (2) @(negedge clock);
        check("an_enable_run", 32'(an_enable), 1);
        reset = 1'b1;
        @(negedge clock);
        m_odd = 0; m_even = 0; m_odd_s = 0; m_even_s = 0;
        check("rrun_an_enable", 32'(an_enable), 0);
        check("rrun_in_ready", 32'(in_ready), 1);
        check("rrun_res_valid", 32'(res_valid), 0);
        check_tallies();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check("rrun_no_res_valid", 32'(res_valid), 0);
        end
        check("rrun_in_ready_after", 32'(in_ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
